// File: rtl/apb_master_ctrl.sv
// APB master sequencer: pops one command from the request FIFO, runs SETUP/ACCESS,
// pushes one {slverr, rdata} response. Optional ACCESS timeout under `APB_TIMEOUT_EN.
module apb_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_empty_i,
    output logic                                 cmd_rden_o,
    input  logic [1+ADDR_W+DATA_W/8+DATA_W-1:0]  cmd_rdata_i,
    input  logic                                 rsp_full_i,
    output logic                                 rsp_wren_o,
    output logic [DATA_W:0]                      rsp_wdata_o,
    output logic                                 psel_o,
    output logic                                 penable_o,
    output logic                                 pwrite_o,
    output logic [ADDR_W-1:0]                    paddr_o,
    output logic [DATA_W-1:0]                    pwdata_o,
    output logic [DATA_W/8-1:0]                  pstrb_o,
    input  logic                                 pready_i,
    input  logic [DATA_W-1:0]                    prdata_i,
    input  logic                                 pslverr_i
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP_WAIT} state_t;

    state_t                r_state, w_next;
    logic                  r_pwrite;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic [DATA_W/8-1:0]   r_pstrb;
    logic [DATA_W:0]       r_rsp;
    logic [DATA_W:0]       w_rsp;
    logic                  w_pop, w_push, w_done, w_timeout;

    logic                  w_cmd_wr;
    logic [ADDR_W-1:0]     w_cmd_addr;
    logic [DATA_W/8-1:0]   w_cmd_strb;
    logic [DATA_W-1:0]     w_cmd_wdata;

    assign {w_cmd_wr, w_cmd_addr, w_cmd_strb, w_cmd_wdata} = cmd_rdata_i;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Fires on the wait cycle that brings the count up to the limit.
    assign w_timeout = (r_state == S_ACCESS) && !pready_i &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == S_SETUP)
            r_cnt <= '0;
        else if (r_state == S_ACCESS && !pready_i)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_push = 1'b0;
        w_done = (r_state == S_ACCESS) && (pready_i || w_timeout);
        // A real PREADY wins over a timeout landing on the same cycle.
        w_rsp  = pready_i ? {pslverr_i, (r_pwrite ? {DATA_W{1'b0}} : prdata_i)}
                          : {1'b1, {DATA_W{1'b0}}};
        case (r_state)
            S_IDLE: begin
                if (!cmd_empty_i) begin
                    w_pop  = 1'b1;
                    w_next = S_SETUP;
                end
            end
            S_SETUP: w_next = S_ACCESS;
            S_ACCESS: begin
                if (w_done) begin
                    if (!rsp_full_i) begin
                        w_push = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_RESP_WAIT;
                    end
                end
            end
            S_RESP_WAIT: begin
                if (!rsp_full_i) begin
                    w_push = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_rsp    <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_pwrite <= w_cmd_wr;
                r_paddr  <= w_cmd_addr;
                r_pstrb  <= w_cmd_strb;
                r_pwdata <= w_cmd_wdata;
            end
            if (w_done)
                r_rsp <= w_rsp;
        end
    end

    // Zero-wait completions bypass the response register.
    assign rsp_wdata_o = (r_state == S_ACCESS) ? w_rsp : r_rsp;
    assign cmd_rden_o  = w_pop & rst_n;
    assign rsp_wren_o  = w_push & rst_n;
    assign psel_o      = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign penable_o   = (r_state == S_ACCESS);
    assign pwrite_o    = r_pwrite;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;
    assign pstrb_o     = r_pstrb;

endmodule
